// File: rtl/sw_debounce_if.sv
// rtl/sw_debounce_if.sv - switch debouncer signal bundle; SW_DEBOUNCE_EDGE_EN adds sw_rise/sw_fall
interface sw_debounce_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out;
  logic             sw_valid;
  logic             sw_changed;
`ifdef SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
`endif

`ifdef SW_DEBOUNCE_EDGE_EN
  // debouncer side
  modport slave (
    input  sw_in,
    output sw_out, sw_valid, sw_changed, sw_rise, sw_fall
  );

  // switch-word consumer side
  modport master (
    output sw_in,
    input  sw_out, sw_valid, sw_changed, sw_rise, sw_fall
  );
`else
  // debouncer side
  modport slave (
    input  sw_in,
    output sw_out, sw_valid, sw_changed
  );

  // switch-word consumer side
  modport master (
    output sw_in,
    input  sw_out, sw_valid, sw_changed
  );
`endif

endinterface

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - per-bit switch synchronizer and debouncer; SW_DEBOUNCE_EDGE_EN adds sw_rise/sw_fall
module sw_debounce #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  sw_debounce_if.slave bus
);

  // Top-level FSM: one settling window after reset, then per-bit debouncing forever.
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Per-bit FSM.
  localparam logic [0:0] BIT_STABLE   = 1'b0;
  localparam logic [0:0] BIT_COUNTING = 1'b1;

  // A new level is accepted on the edge where the counter already shows DEBOUNCE_CYCLES-1,
  // so the mismatch has then been seen on DEBOUNCE_CYCLES consecutive edges.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     sync_d [SYNC_STAGES];
  logic [WIDTH-1:0]     sync_lvl;

  logic [0:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] init_cnt_q, init_cnt_d;

  logic [WIDTH-1:0]     bit_st_q, bit_st_d;
  logic [CNT_WIDTH-1:0] bit_cnt_q [WIDTH];
  logic [CNT_WIDTH-1:0] bit_cnt_d [WIDTH];

  logic [WIDTH-1:0]     sw_out_q, sw_out_d;
  logic                 sw_valid_q, sw_valid_d;
  logic                 sw_changed_q, sw_changed_d;
`ifdef SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0]     sw_rise_q, sw_rise_d;
  logic [WIDTH-1:0]     sw_fall_q, sw_fall_d;
`endif

  // Synchronizer chain: stage 0 samples the raw pins, the last stage is the only level used downstream.
  always_comb begin
    sync_d[0] = bus.sw_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Next-state logic for the settling window, the per-bit debouncers and the strobes.
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    bit_st_d     = bit_st_q;
    bit_cnt_d    = bit_cnt_q;
    sw_out_d     = sw_out_q;
    sw_valid_d   = sw_valid_q;
    sw_changed_d = 1'b0;
`ifdef SW_DEBOUNCE_EDGE_EN
    sw_rise_d    = '0;
    sw_fall_d    = '0;
`endif

    case (state_q)
      ST_INIT: begin
        // The initial load is not a change, so no strobe is raised here.
        if (init_cnt_q == CNT_LAST) begin
          sw_out_d   = sync_lvl;
          sw_valid_d = 1'b1;
          init_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + CNT_ONE;
        end
      end

      default: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (sync_lvl[i] == sw_out_q[i]) begin
            // Level agrees (or bounced back): drop any partial progress.
            bit_st_d[i]  = BIT_STABLE;
            bit_cnt_d[i] = '0;
          end else if (bit_st_q[i] == BIT_STABLE) begin
            bit_st_d[i]  = BIT_COUNTING;
            bit_cnt_d[i] = CNT_ONE;
          end else if (bit_cnt_q[i] == CNT_LAST) begin
            sw_out_d[i]  = sync_lvl[i];
            bit_st_d[i]  = BIT_STABLE;
            bit_cnt_d[i] = '0;
          end else begin
            bit_cnt_d[i] = bit_cnt_q[i] + CNT_ONE;
          end
        end

        // All bits qualifying on the same edge share one strobe.
        sw_changed_d = (sw_out_d != sw_out_q);
`ifdef SW_DEBOUNCE_EDGE_EN
        sw_rise_d    = ~sw_out_q & sw_out_d;
        sw_fall_d    = sw_out_q & ~sw_out_d;
`endif
      end
    endcase
  end

  // State registers; reset discards all synchronizer and counter progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        bit_cnt_q[i] <= '0;
      end
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      bit_st_q     <= '0;
      sw_out_q     <= '0;
      sw_valid_q   <= 1'b0;
      sw_changed_q <= 1'b0;
`ifdef SW_DEBOUNCE_EDGE_EN
      sw_rise_q    <= '0;
      sw_fall_q    <= '0;
`endif
    end else begin
      sync_q       <= sync_d;
      bit_cnt_q    <= bit_cnt_d;
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      bit_st_q     <= bit_st_d;
      sw_out_q     <= sw_out_d;
      sw_valid_q   <= sw_valid_d;
      sw_changed_q <= sw_changed_d;
`ifdef SW_DEBOUNCE_EDGE_EN
      sw_rise_q    <= sw_rise_d;
      sw_fall_q    <= sw_fall_d;
`endif
    end
  end

  assign bus.sw_out     = sw_out_q;
  assign bus.sw_valid   = sw_valid_q;
  assign bus.sw_changed = sw_changed_q;
`ifdef SW_DEBOUNCE_EDGE_EN
  assign bus.sw_rise    = sw_rise_q;
  assign bus.sw_fall    = sw_fall_q;
`endif

endmodule
